quot_bcd_conv: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 method (double dabble).
- Sits directly downstream of the 16-bit divider and takes its quotient output O.
- Produces packed BCD digits plus a significant-digit count for the display/monitor stage.
- Uses a valid/ready handshake on both sides and converts one operand at a time.

---
 rtl/quot_bcd_conv_pkg.sv | 21 ++
 rtl/quot_bcd_conv_if.sv | 28 ++
 rtl/quot_bcd_conv_add3.sv | 12 +
 rtl/quot_bcd_conv.sv | 114 +++++++++++
 tb/tb_quot_bcd_conv.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quot_bcd_conv_pkg.sv
// Shared types and constants for the quotient-to-BCD converter.
// Defines the FSM encoding, the digit-correction constants and the counter sizing helper.
package quot_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_VAL    = 3;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DIGITS     = 5;

  // Counter must be able to hold the terminal count WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/quot_bcd_conv_if.sv
// Handshake bundle between the divider side, the converter and the display stage.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface quot_bcd_conv_if
  import quot_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [2:0]            nz_digits;

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, nz_digits
  );

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, nz_digits
  );

endinterface

// File: rtl/quot_bcd_conv_add3.sv
// Single-digit double-dabble corrector: adds 3 to a digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import quot_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'(BCD_ADJ_THRESH)) ? (i_digit + 4'(BCD_ADJ_VAL)) : i_digit;

endmodule

// File: rtl/quot_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per cycle.
// Accepts one quotient at a time and presents packed BCD plus a significant-digit count.
module quot_bcd_conv
  import quot_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
)(
  input  logic            CLK,
  input  logic            RST_N,
  quot_bcd_conv_if.slave  bus,
  output state_t          o_state
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = 4 * DIGITS;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_bcd_shift;
  logic [BCD_W-1:0]    r_bcd_out;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic [2:0]          r_nz;
  logic [2:0]          w_nz;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_last;
  logic                w_done_hs;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_bcd[4*g +: 4]),
        .o_digit (w_bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // Corrected digits shifted left, pulling in the next binary MSB.
  assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_in_ready  = (r_state == IDLE) && RST_N;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_done_hs   = r_out_valid && bus.out_ready;

  always_comb begin
    w_nz = 3'd1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_bcd_shift[4*d +: 4] != 4'd0) w_nz = 3'(d + 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_done_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out_valid <= 1'b0;
      r_bcd_out   <= '0;
      r_nz        <= 3'd1;
      r_cnt       <= '0;
      r_bin       <= '0;
      r_bcd       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_bin <= bus.bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_bcd_out   <= w_bcd_shift;
            r_nz        <= w_nz;
          end
        end
        DONE: begin
          if (w_done_hs) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.bcd_out   = r_bcd_out;
  assign bus.nz_digits = r_nz;
  assign o_state       = r_state;

endmodule

// File: tb/tb_quot_bcd_conv.sv
// Self-checking bench for quot_bcd_conv: decimal reference model feeding an expected-result queue.
module tb_quot_bcd_conv;
  import quot_bcd_pkg::*;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int RW     = BCD_W + 3;

  // ---------------- clock / reset ----------------
  logic   CLK   = 1'b0;
  logic   RST_N = 1'b0;
  state_t dbg_state;
  int     cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  quot_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  quot_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] model(input int v);
    logic [BCD_W-1:0] b;
    logic [2:0] nz;
    int x;
    b  = '0;
    nz = 3'd1;
    x  = v;
    for (int d = 0; d < DIGITS; d++) begin
      b[4*d +: 4] = 4'(x % 10);
      if ((x % 10) != 0) nz = 3'(d + 1);
      x = x / 10;
    end
    return {nz, b};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves in_valid high, returns one negedge after the accepting edge.
  task automatic send(input int v, output int acc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.bin_in   = 16'(v);
    while (!bus.in_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout value=%0d in_ready=%b required 1", v, bus.in_ready);
      acc = -1;
      return;
    end
    exp_q.push_back(model(v));
    acc = cyc + 1;
    @(negedge CLK);
    bus.bin_in = 16'($urandom_range(0, 65535));
  endtask

  // Waits for out_valid, pops the scoreboard and checks value and (optionally) latency.
  task automatic get_result(input string name, input int acc);
    int n;
    logic [RW-1:0] exp;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s_timeout out_valid=%b required 1", name, bus.out_valid);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected got=%h/%0d no expected entry", name, bus.bcd_out, bus.nz_digits);
    end else begin
      exp = exp_q.pop_front();
      if ({bus.nz_digits, bus.bcd_out} !== exp)
        begin
          errors++;
          $display("FAIL %s bcd=%h nz=%0d required bcd=%h nz=%0d",
                   name, bus.bcd_out, bus.nz_digits, exp[BCD_W-1:0], exp[RW-1:BCD_W]);
        end
    end
    if (acc >= 0) begin
      checks++;
      if (cyc != acc + WIDTH) begin
        errors++;
        $display("FAIL %s_latency cycles=%0d required %0d", name, cyc - acc, WIDTH);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.bin_in    = 16'd5;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d required %0d", dbg_state, IDLE); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required 0", bus.out_valid); end
    checks++;
    if (bus.bcd_out !== '0) begin errors++; $display("FAIL rst_bcd got=%h required 0", bus.bcd_out); end
    checks++;
    if (bus.nz_digits !== 3'd1) begin errors++; $display("FAIL rst_nz got=%0d required 1", bus.nz_digits); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    RST_N        = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b required 1", bus.in_ready); end
  endtask

  task automatic test_values();
    int vals[4] = '{1, 105, 0, 65535};
    int acc;
    bus.out_ready = 1'b1;
    foreach (vals[i]) begin
      send(vals[i], acc);
      bus.in_valid = 1'b0;
      get_result($sformatf("value_%0d", vals[i]), acc);
      @(negedge CLK);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL value_%0d_release out_valid=%b in_ready=%b required 0/1",
                 vals[i], bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int rises;
    bus.out_ready = 1'b0;
    send(9, acc);
    bus.in_valid = 1'b0;
    get_result("bp_value", acc);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.bin_in   = 16'd7;
      @(negedge CLK);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.bcd_out !== 20'h00009 || bus.in_ready !== 1'b0 || dbg_state !== DONE) begin
        errors++;
        $display("FAIL bp_hold_%0d out_valid=%b bcd=%h in_ready=%b state=%0d required 1/00009/0/%0d",
                 i, bus.out_valid, bus.bcd_out, bus.in_ready, dbg_state, DONE);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bcd_out !== 20'h00009) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b bcd=%h required 0/1/00009",
               bus.out_valid, bus.in_ready, bus.bcd_out);
    end
    rises = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.out_valid) rises++;
    end
    checks++;
    if (rises != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_ignored_inputs extra_valid_cycles=%0d pending=%0d required 0/0", rises, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bus.out_ready = 1'b1;
    send(31, acc);
    bus.in_valid = 1'b0;
    while (cyc < acc + 6) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.bcd_out !== '0 || bus.nz_digits !== 3'd1) begin
      errors++;
      $display("FAIL mid_reset state=%0d out_valid=%b bcd=%h nz=%0d required %0d/0/00000/1",
               dbg_state, bus.out_valid, bus.bcd_out, bus.nz_digits, IDLE);
    end
    exp_q.delete();
    RST_N = 1'b1;
    send(6, acc);
    bus.in_valid = 1'b0;
    get_result("after_reset", acc);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int vals[3] = '{12, 105, 31};
    int accs[3];
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int a;
          send(vals[i], a);
          accs[i] = a;
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) begin
          get_result($sformatf("b2b_%0d", j), -1);
          @(negedge CLK);
          checks++;
          if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse_%0d out_valid=%b required 0", j, bus.out_valid);
          end
        end
      end
    join
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (accs[k] - accs[k-1] != WIDTH + 2) begin
        errors++;
        $display("FAIL b2b_spacing_%0d got=%0d required %0d", k, accs[k] - accs[k-1], WIDTH + 2);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_values();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
